// File: rtl/pmod_req_arbiter.sv
// Round-robin arbiter sharing the budIf command port between two requesters; one pending slot each.
// Grant-to-command is 2 cycles from request pulse; requesters see backpressure via busy (pulses while busy are dropped).
module pmod_req_arbiter #(
  parameter int LEN_W    = 10,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int START_TO = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_write_req,
  input  logic              r1_write_req,
  input  logic              r0_read_req,
  input  logic              r1_read_req,
  input  logic [LEN_W-1:0]  r0_len,
  input  logic [LEN_W-1:0]  r1_len,
  input  logic [ADDR_W-1:0] r0_address,
  input  logic [ADDR_W-1:0] r1_address,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r0_busy,
  output logic              r1_busy,
  output logic              r0_done,
  output logic              r1_done,
  output logic              m_write_req,
  output logic              m_read_req,
  output logic [LEN_W-1:0]  m_len,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_busy,
  output logic              owner,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  localparam int CNT_W = $clog2(START_TO + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TO - 1);

  state_t state, state_nxt;

  logic [1:0]        wr_req, rd_req;
  logic [1:0]        pend, pend_nxt, pend_is_wr, wr_nxt, clr, done_q;
  logic [LEN_W-1:0]  len_in [2];
  logic [LEN_W-1:0]  len_q [2];
  logic [LEN_W-1:0]  len_nxt [2];
  logic [ADDR_W-1:0] addr_in [2];
  logic [ADDR_W-1:0] addr_q [2];
  logic [ADDR_W-1:0] addr_nxt [2];
  logic [CNT_W-1:0]  cnt;
  logic              last_grant, grant, win, abort, finish;

  assign wr_req     = {r1_write_req, r0_write_req};
  assign rd_req     = {r1_read_req, r0_read_req};
  assign len_in[0]  = r0_len;
  assign len_in[1]  = r1_len;
  assign addr_in[0] = r0_address;
  assign addr_in[1] = r1_address;

  // Slot release for the current owner: start timeout or bus-master completion.
  always_comb begin
    clr    = 2'b00;
    abort  = 1'b0;
    finish = 1'b0;
    case (state)
      WAIT_BUSY: if (!m_busy && cnt == CNT_LAST) begin
        abort      = 1'b1;
        clr[owner] = 1'b1;
      end
      WAIT_DONE: if (!m_busy) begin
        finish     = 1'b1;
        clr[owner] = 1'b1;
      end
      default: ;
    endcase
  end

  // Clear happens first, so a pulse in the clearing cycle refills the slot; write beats read.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      logic keep_i, take_i;
      keep_i      = pend[i] & ~clr[i];
      take_i      = ~keep_i & (wr_req[i] | rd_req[i]);
      pend_nxt[i] = keep_i | take_i;
      wr_nxt[i]   = take_i ? wr_req[i]  : pend_is_wr[i];
      len_nxt[i]  = take_i ? len_in[i]  : len_q[i];
      addr_nxt[i] = take_i ? addr_in[i] : addr_q[i];
    end
  end

  // Arbitrating on pend_nxt lets a pulse into an idle arbiter reach ISSUE the very next cycle.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    win       = 1'b0;
    case (state)
      IDLE: if (|pend_nxt) begin
        grant     = 1'b1;
        win       = (&pend_nxt) ? ~last_grant : pend_nxt[1];
        state_nxt = ISSUE;
      end
      ISSUE:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (m_busy) state_nxt = WAIT_DONE;
                 else if (abort) state_nxt = IDLE;
      WAIT_DONE: if (finish) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend        <= 2'b00;
      pend_is_wr  <= 2'b00;
      len_q[0]    <= '0;
      len_q[1]    <= '0;
      addr_q[0]   <= '0;
      addr_q[1]   <= '0;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      m_len       <= '0;
      m_address   <= '0;
      m_write_req <= 1'b0;
      m_read_req  <= 1'b0;
      done_q      <= 2'b00;
      err         <= 1'b0;
      cnt         <= '0;
    end else begin
      pend        <= pend_nxt;
      pend_is_wr  <= wr_nxt;
      len_q[0]    <= len_nxt[0];
      len_q[1]    <= len_nxt[1];
      addr_q[0]   <= addr_nxt[0];
      addr_q[1]   <= addr_nxt[1];
      m_write_req <= (state == ISSUE) &&  pend_is_wr[owner];
      m_read_req  <= (state == ISSUE) && !pend_is_wr[owner];
      done_q      <= finish ? (owner ? 2'b10 : 2'b01) : 2'b00;
      err         <= abort;
      if (grant) begin
        owner      <= win;
        last_grant <= win;
        m_len      <= len_nxt[win];
        m_address  <= addr_nxt[win];
      end
      if (state == ISSUE)
        cnt <= '0;
      else if (state == WAIT_BUSY && !m_busy)
        cnt <= cnt + 1'b1;
    end
  end

  assign r0_busy = pend[0];
  assign r1_busy = pend[1];
  assign r0_done = done_q[0];
  assign r1_done = done_q[1];
  assign m_wdata = (state == IDLE) ? '0 : (owner ? r1_wdata : r0_wdata);

endmodule

// File: tb/tb_pmod_req_arbiter.sv
// Scoreboard bench for pmod_req_arbiter: stimulus pushes expected bus commands and
// completions; a negedge monitor pops and compares whenever the DUT presents one.
module tb_pmod_req_arbiter;

  logic        clk, reset;
  logic        r0_write_req, r1_write_req, r0_read_req, r1_read_req;
  logic [9:0]  r0_len, r1_len, m_len;
  logic [31:0] r0_address, r1_address, m_address;
  logic [63:0] r0_wdata, r1_wdata, m_wdata;
  logic        r0_busy, r1_busy, r0_done, r1_done;
  logic        m_write_req, m_read_req, m_busy, owner, err;

  pmod_req_arbiter dut (
    .clk(clk), .reset(reset),
    .r0_write_req(r0_write_req), .r1_write_req(r1_write_req),
    .r0_read_req(r0_read_req), .r1_read_req(r1_read_req),
    .r0_len(r0_len), .r1_len(r1_len),
    .r0_address(r0_address), .r1_address(r1_address),
    .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
    .r0_busy(r0_busy), .r1_busy(r1_busy),
    .r0_done(r0_done), .r1_done(r1_done),
    .m_write_req(m_write_req), .m_read_req(m_read_req),
    .m_len(m_len), .m_address(m_address), .m_wdata(m_wdata),
    .m_busy(m_busy), .owner(owner), .err(err)
  );

  typedef struct packed {
    logic        wr;
    logic        own;
    logic [9:0]  len;
    logic [31:0] addr;
  } cmd_t;

  localparam int C_DONE0 = 0, C_DONE1 = 1, C_ERR = 2;

  cmd_t cmd_q[$];
  int   comp_q[$];
  int   n_cmp = 0, n_err = 0;
  int   cyc = 0, cmd_cyc = -1, done_cyc = -1;
  int   bm_hold = 6, bm_left = 0;
  logic bm_dead = 1'b0, bm_start = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic comp_seen(input int code);
    done_cyc = cyc;
    if (comp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_completion: got code %0d expected none (cycle %0d)", code, cyc);
    end else begin
      chk("completion", code, comp_q.pop_front());
    end
  endtask

  // Monitor
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (m_write_req || m_read_req) begin
        cmd_cyc = cyc;
        if (cmd_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_cmd: got wr=%0b rd=%0b addr=%h expected none", m_write_req, m_read_req, m_address);
        end else begin
          cmd_t e;
          e = cmd_q.pop_front();
          chk("cmd_kind", {m_write_req, m_read_req}, {e.wr, ~e.wr});
          chk("cmd_owner", owner, e.own);
          chk("cmd_len", m_len, e.len);
          chk("cmd_addr", m_address, e.addr);
        end
      end
      if (r0_done) comp_seen(C_DONE0);
      if (r1_done) comp_seen(C_DONE1);
      if (err)     comp_seen(C_ERR);
    end
  end

  // Bus-master model: busy rises the cycle after a command pulse and lasts bm_hold cycles.
  initial forever begin
    @(posedge clk);
    #2;
    if (reset) begin
      m_busy   = 1'b0;
      bm_left  = 0;
      bm_start = 1'b0;
    end else begin
      if (m_busy) begin
        bm_left--;
        if (bm_left == 0) m_busy = 1'b0;
      end
      if (bm_start && !bm_dead) begin
        m_busy  = 1'b1;
        bm_left = bm_hold;
      end
      bm_start = m_write_req || m_read_req;
    end
  end

  task automatic req(input logic w0, input logic rd0, input logic [9:0] l0, input logic [31:0] a0,
                     input logic w1, input logic rd1, input logic [9:0] l1, input logic [31:0] a1,
                     output int t);
    @(posedge clk);
    #1;
    t            = cyc;
    r0_write_req = w0;  r0_read_req = rd0; r0_len = l0; r0_address = a0;
    r1_write_req = w1;  r1_read_req = rd1; r1_len = l1; r1_address = a1;
    @(posedge clk);
    #1;
    r0_write_req = 1'b0; r0_read_req = 1'b0;
    r1_write_req = 1'b0; r1_read_req = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!r0_busy && !r1_busy && !m_busy) break;
    end
    chk(nm, {r0_busy, r1_busy, m_busy}, 3'b000);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_busy"}, {r0_busy, r1_busy}, 2'b00);
    chk({nm, "_done"}, {r0_done, r1_done}, 2'b00);
    chk({nm, "_mreq"}, {m_write_req, m_read_req}, 2'b00);
    chk({nm, "_owner"}, owner, 1'b0);
    chk({nm, "_m_len"}, m_len, 10'd0);
    chk({nm, "_m_addr"}, m_address, 32'd0);
    chk({nm, "_m_wdata"}, m_wdata, 64'd0);
    chk({nm, "_err"}, err, 1'b0);
  endtask

  initial begin
    int t, te;
    reset = 1'b1;
    r0_write_req = 1'b0; r0_read_req = 1'b0; r0_len = '0; r0_address = '0;
    r1_write_req = 1'b0; r1_read_req = 1'b0; r1_len = '0; r1_address = '0;
    r0_wdata = 64'h1111_2222_3333_4444;
    r1_wdata = 64'h5555_6666_7777_8888;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // Tie from reset: last_grant=1 so r0 goes first
    cmd_q.push_back('{1'b0, 1'b0, 10'd2, 32'h100});
    cmd_q.push_back('{1'b1, 1'b1, 10'd3, 32'h200});
    comp_q.push_back(C_DONE0);
    comp_q.push_back(C_DONE1);
    req(1'b0, 1'b1, 10'd2, 32'h100, 1'b1, 1'b0, 10'd3, 32'h200, t);
    wait_idle("tieA_idle");

    // Single write from r0 with timing checks
    cmd_q.push_back('{1'b1, 1'b0, 10'd4, 32'h1000_0000});
    comp_q.push_back(C_DONE0);
    req(1'b1, 1'b0, 10'd4, 32'h1000_0000, 1'b0, 1'b0, 10'd0, 32'h0, t);
    chk("w1_busy_t1", r0_busy, 1'b1);
    chk("w1_wdata_owner", m_wdata, 64'h1111_2222_3333_4444);
    wait_idle("w1_idle");
    chk("w1_cmd_cycle", cmd_cyc, t + 2);
    chk("w1_done_cycle", done_cyc, t + 10);
    chk("w1_owner", owner, 1'b0);

    // Tie again after an r0 grant: r1 goes first
    cmd_q.push_back('{1'b1, 1'b1, 10'd3, 32'h200});
    cmd_q.push_back('{1'b0, 1'b0, 10'd2, 32'h100});
    comp_q.push_back(C_DONE1);
    comp_q.push_back(C_DONE0);
    req(1'b0, 1'b1, 10'd2, 32'h100, 1'b1, 1'b0, 10'd3, 32'h200, t);
    wait_idle("tieB_idle");

    // r1 write data passthrough while owner
    cmd_q.push_back('{1'b1, 1'b1, 10'd1, 32'h300});
    comp_q.push_back(C_DONE1);
    req(1'b0, 1'b0, 10'd0, 32'h0, 1'b1, 1'b0, 10'd1, 32'h300, t);
    for (int k = 0; k < 20 && !m_busy; k++) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 r1_wdata = 64'hA5A5_0000_0000_0000 + 64'(i);
      #1 chk("wdata_track", m_wdata, 64'hA5A5_0000_0000_0000 + 64'(i));
    end
    wait_idle("wdata_idle");
    chk("wdata_idle_zero", m_wdata, 64'd0);

    // Second pulse while pending is dropped
    cmd_q.push_back('{1'b1, 1'b0, 10'd5, 32'h400});
    comp_q.push_back(C_DONE0);
    req(1'b1, 1'b0, 10'd5, 32'h400, 1'b0, 1'b0, 10'd0, 32'h0, t);
    req(1'b1, 1'b0, 10'd6, 32'h500, 1'b0, 1'b0, 10'd0, 32'h0, t);
    wait_idle("dup_idle");

    // Write and read in the same cycle: write only
    cmd_q.push_back('{1'b1, 1'b0, 10'd7, 32'h600});
    comp_q.push_back(C_DONE0);
    req(1'b1, 1'b1, 10'd7, 32'h600, 1'b0, 1'b0, 10'd0, 32'h0, t);
    wait_idle("wr_rd_idle");

    // Start timeout on r0 with r1 queued behind it
    bm_dead = 1'b1;
    cmd_q.push_back('{1'b1, 1'b0, 10'd8, 32'h700});
    cmd_q.push_back('{1'b0, 1'b1, 10'd9, 32'h800});
    comp_q.push_back(C_ERR);
    comp_q.push_back(C_DONE1);
    req(1'b1, 1'b0, 10'd8, 32'h700, 1'b0, 1'b0, 10'd0, 32'h0, t);
    req(1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 1'b1, 10'd9, 32'h800, te);
    te = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (err) begin
        te = cyc;
        break;
      end
    end
    chk("to_err_cycle", te, t + 17);
    chk("to_busy_after", {r0_busy, r1_busy}, 2'b01);
    bm_dead = 1'b0;
    wait_idle("to_idle");

    // Reset during WAIT_DONE with r1 pending
    bm_hold = 10;
    cmd_q.push_back('{1'b1, 1'b0, 10'd3, 32'h900});
    req(1'b1, 1'b0, 10'd3, 32'h900, 1'b0, 1'b0, 10'd0, 32'h0, t);
    req(1'b0, 1'b0, 10'd0, 32'h0, 1'b1, 1'b0, 10'd4, 32'hA00, t);
    for (int k = 0; k < 20 && !m_busy; k++) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");

    bm_hold = 6;
    cmd_q.push_back('{1'b1, 1'b1, 10'd5, 32'hB00});
    comp_q.push_back(C_DONE1);
    req(1'b0, 1'b0, 10'd0, 32'h0, 1'b1, 1'b0, 10'd5, 32'hB00, t);
    wait_idle("post_reset_idle");
    chk("post_reset_owner", owner, 1'b1);

    repeat (5) @(negedge clk);
    chk("cmd_queue_empty", cmd_q.size(), 0);
    chk("comp_queue_empty", comp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
